// File: rtl/n64_rtc_timekeeper.sv
// SI RTC responder: free-running 42-bit BCD calendar clock with a pending/done load handshake.
// Optional leap-year February (0x29 when the BCD year is divisible by 4) via RTC_LEAP_YEAR_EN.
module n64_rtc_timekeeper #(
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rtc_stop,
  input  logic        rtc_pending,
  input  logic [41:0] rtc_rdata,
  output logic        rtc_done,
  output logic        rtc_wdata_valid,
  output logic [41:0] rtc_wdata
);

  localparam int DIV_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLOCK_FREQ - 1);
  // 2000-01-01, weekday 6, 00:00:00
  localparam logic [41:0] RESET_TIME = {8'h00, 5'h01, 6'h01, 3'd6, 6'h00, 7'h00, 7'h00};

  logic [41:0]      time_q;
  logic [41:0]      time_adv;
  logic [DIV_W-1:0] div_q;
  logic             req_flag;
  logic             ack_p0;
  logic             tick;
  logic             service;
  logic [7:0]       feb_days;
  logic [7:0]       dim;

  logic [6:0] t_sec;
  logic [6:0] t_min;
  logic [5:0] t_hour;
  logic [2:0] t_wd;
  logic [5:0] t_day;
  logic [4:0] t_mon;
  logic [7:0] t_yr;

  assign t_sec  = time_q[6:0];
  assign t_min  = time_q[13:7];
  assign t_hour = time_q[19:14];
  assign t_wd   = time_q[22:20];
  assign t_day  = time_q[28:23];
  assign t_mon  = time_q[33:29];
  assign t_yr   = time_q[41:34];

  // Codes at or above the field maximum (including invalid BCD) roll to the reset value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v,
                                         input logic [7:0] rst_v);
    if (v >= max_v)
      return rst_v;
    else if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] month_days(input logic [4:0] mon, input logic [7:0] feb);
    case (mon)
      5'h04, 5'h06, 5'h09, 5'h11: return 8'h30;
      5'h02:                      return feb;
      default:                    return 8'h31;
    endcase
  endfunction

`ifdef RTC_LEAP_YEAR_EN
  function automatic logic is_leap(input logic [7:0] yr);
    if (!yr[4])
      return (yr[3:0] == 4'd0) || (yr[3:0] == 4'd4) || (yr[3:0] == 4'd8);
    else
      return (yr[3:0] == 4'd2) || (yr[3:0] == 4'd6);
  endfunction

  assign feb_days = is_leap(t_yr) ? 8'h29 : 8'h28;
`else
  assign feb_days = 8'h28;
`endif

  assign dim     = month_days(t_mon, feb_days);
  assign tick    = !rtc_stop && (div_q == DIV_MAX);
  assign service = rtc_pending && !req_flag;

  always_comb begin
    time_adv       = time_q;
    time_adv[6:0]  = 7'(bcd_inc({1'b0, t_sec}, 8'h59, 8'h00));
    if ({1'b0, t_sec} >= 8'h59) begin
      time_adv[13:7] = 7'(bcd_inc({1'b0, t_min}, 8'h59, 8'h00));
      if ({1'b0, t_min} >= 8'h59) begin
        time_adv[19:14] = 6'(bcd_inc({2'b0, t_hour}, 8'h23, 8'h00));
        if ({2'b0, t_hour} >= 8'h23) begin
          time_adv[22:20] = (t_wd == 3'd6) ? 3'd0 : t_wd + 3'd1;
          time_adv[28:23] = 6'(bcd_inc({2'b0, t_day}, dim, 8'h01));
          if ({2'b0, t_day} >= dim) begin
            time_adv[33:29] = 5'(bcd_inc({3'b0, t_mon}, 8'h12, 8'h01));
            if ({3'b0, t_mon} >= 8'h12)
              time_adv[41:34] = bcd_inc(t_yr, 8'h99, 8'h00);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q          <= RESET_TIME;
      div_q           <= '0;
      req_flag        <= 1'b0;
      ack_p0          <= 1'b0;
      rtc_done        <= 1'b0;
      rtc_wdata_valid <= 1'b0;
    end else begin
      req_flag <= rtc_pending;
      // p0: load accepted; acknowledge leaves one cycle later
      ack_p0   <= service;
      rtc_done <= ack_p0;
      if (service) begin
        time_q          <= rtc_rdata;
        div_q           <= '0;
        rtc_wdata_valid <= 1'b1;
      end else if (!rtc_stop) begin
        if (tick) begin
          div_q  <= '0;
          time_q <= time_adv;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  assign rtc_wdata = time_q;

endmodule

// File: tb/tb_n64_rtc_timekeeper.sv
// Bench for n64_rtc_timekeeper: vector table of write-then-tick cases, handshake corner sequences,
// and randomized traffic against a field-level calendar model.
module tb_n64_rtc_timekeeper;
  localparam int CF = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        rtc_stop;
  logic        rtc_pending;
  logic [41:0] rtc_rdata;
  logic        rtc_done;
  logic        rtc_wdata_valid;
  logic [41:0] rtc_wdata;

  n64_rtc_timekeeper #(.CLOCK_FREQ(CF)) dut (
    .clk(clk), .reset(reset), .rtc_stop(rtc_stop), .rtc_pending(rtc_pending),
    .rtc_rdata(rtc_rdata), .rtc_done(rtc_done), .rtc_wdata_valid(rtc_wdata_valid),
    .rtc_wdata(rtc_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // model: fields as integers, index 0 sec,1 min,2 hour,3 weekday,4 day,5 month,6 year
  int m_t[7];
  int m_div = 0;
  bit m_flag = 0, m_ack = 0, m_done = 0, m_valid = 0;

  function automatic logic [41:0] pack(int yr, int mon, int day, int wd, int hr, int mn, int sc);
    return {yr[7:0], mon[4:0], day[5:0], wd[2:0], hr[5:0], mn[6:0], sc[6:0]};
  endfunction

  function automatic logic [41:0] model_time();
    return pack(m_t[6], m_t[5], m_t[4], m_t[3], m_t[2], m_t[1], m_t[0]);
  endfunction

  localparam logic [41:0] RST_T = {8'h00, 5'h01, 6'h01, 3'd6, 6'h00, 7'h00, 7'h00};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int inc_code(int v, int mx, int rv, int bits);
    int r;
    if (v >= mx) r = rv;
    else if (v % 16 >= 9) r = (v / 16 + 1) * 16;
    else r = v + 1;
    return r % (1 << bits);
  endfunction

  function automatic bit leap(int yr);
    int tens = yr / 16;
    int u = yr % 16;
`ifdef RTC_LEAP_YEAR_EN
    if (tens % 2 == 0) return (u == 0 || u == 4 || u == 8);
    return (u == 2 || u == 6);
`else
    return (tens < 0) && (u < 0);
`endif
  endfunction

  function automatic int days_in(int mon, int yr);
    case (mon)
      'h04, 'h06, 'h09, 'h11: return 'h30;
      'h02: return leap(yr) ? 'h29 : 'h28;
      default: return 'h31;
    endcase
  endfunction

  task automatic model_advance();
    bit c;
    int dim;
    c = (m_t[0] >= 'h59); m_t[0] = inc_code(m_t[0], 'h59, 0, 7);
    if (!c) return;
    c = (m_t[1] >= 'h59); m_t[1] = inc_code(m_t[1], 'h59, 0, 7);
    if (!c) return;
    c = (m_t[2] >= 'h23); m_t[2] = inc_code(m_t[2], 'h23, 0, 6);
    if (!c) return;
    m_t[3] = (m_t[3] == 6) ? 0 : (m_t[3] + 1) % 8;
    dim = days_in(m_t[5], m_t[6]);
    c = (m_t[4] >= dim); m_t[4] = inc_code(m_t[4], dim, 1, 6);
    if (!c) return;
    c = (m_t[5] >= 'h12); m_t[5] = inc_code(m_t[5], 'h12, 1, 5);
    if (!c) return;
    m_t[6] = inc_code(m_t[6], 'h99, 0, 8);
  endtask

  // Advance the model using the inputs currently driven, clock the DUT, then compare.
  task automatic cycle();
    bit svc;
    if (reset) begin
      m_t = '{0, 0, 0, 6, 1, 1, 0};
      m_div = 0; m_flag = 0; m_ack = 0; m_done = 0; m_valid = 0;
    end else begin
      svc    = rtc_pending && !m_flag;
      m_done = m_ack;
      m_ack  = svc;
      m_flag = rtc_pending;
      if (svc) begin
        m_t[0] = int'(rtc_rdata[6:0]);   m_t[1] = int'(rtc_rdata[13:7]);
        m_t[2] = int'(rtc_rdata[19:14]); m_t[3] = int'(rtc_rdata[22:20]);
        m_t[4] = int'(rtc_rdata[28:23]); m_t[5] = int'(rtc_rdata[33:29]);
        m_t[6] = int'(rtc_rdata[41:34]);
        m_div = 0; m_valid = 1;
      end else if (!rtc_stop) begin
        if (m_div == CF - 1) begin
          m_div = 0;
          model_advance();
        end else begin
          m_div++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rtc_done === 1'b1) done_cnt++;
    check("wdata", 64'(rtc_wdata), 64'(model_time()));
    check("done", 64'(rtc_done), 64'(m_done));
    check("valid", 64'(rtc_wdata_valid), 64'(m_valid));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1; rtc_pending = 1'b0; rtc_stop = 1'b0;
    run(2);
    reset = 1'b0;
  endtask

  task automatic write(input logic [41:0] v);
    rtc_rdata = v; rtc_pending = 1'b1;
    cycle();
    rtc_pending = 1'b0;
  endtask

  typedef struct {
    logic [41:0] wr;
    logic [41:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic int rand_bcd(int lo, int hi);
    int d = int'($urandom_range(hi, lo));
    return (d / 10) * 16 + d % 10;
  endfunction

  initial begin
    logic [41:0] v;
    int start;
    bit pend;
    reset = 1'b1; rtc_stop = 1'b0; rtc_pending = 1'b0; rtc_rdata = '0;
    m_t = '{0, 0, 0, 6, 1, 1, 0};

    vecs[0] = '{pack('h99, 'h12, 'h31, 6, 'h23, 'h59, 'h59), pack('h00, 'h01, 'h01, 0, 0, 0, 0)};
`ifdef RTC_LEAP_YEAR_EN
    vecs[1] = '{pack('h24, 'h02, 'h28, 3, 'h23, 'h59, 'h59), pack('h24, 'h02, 'h29, 4, 0, 0, 0)};
    vecs[8] = '{pack('h00, 'h02, 'h28, 6, 'h23, 'h59, 'h59), pack('h00, 'h02, 'h29, 0, 0, 0, 0)};
`else
    vecs[1] = '{pack('h24, 'h02, 'h28, 3, 'h23, 'h59, 'h59), pack('h24, 'h03, 'h01, 4, 0, 0, 0)};
    vecs[8] = '{pack('h00, 'h02, 'h28, 6, 'h23, 'h59, 'h59), pack('h00, 'h03, 'h01, 0, 0, 0, 0)};
`endif
    vecs[2] = '{pack('h23, 'h02, 'h28, 3, 'h23, 'h59, 'h59), pack('h23, 'h03, 'h01, 4, 0, 0, 0)};
    vecs[3] = '{pack('h00, 'h01, 'h01, 6, 0, 0, 'h09), pack('h00, 'h01, 'h01, 6, 0, 0, 'h10)};
    vecs[4] = '{pack('h24, 'h04, 'h30, 1, 'h23, 'h59, 'h59), pack('h24, 'h05, 'h01, 2, 0, 0, 0)};
    vecs[5] = '{pack('h24, 'h06, 'h15, 2, 'h10, 'h00, 'h7A), pack('h24, 'h06, 'h15, 2, 'h10, 'h01, 0)};
    vecs[6] = '{pack('h24, 'h15, 'h31, 5, 'h23, 'h59, 'h59), pack('h25, 'h01, 'h01, 6, 0, 0, 0)};
    vecs[7] = '{pack('h50, 'h07, 'h19, 7, 'h23, 'h59, 'h59), pack('h50, 'h07, 'h20, 0, 0, 0, 0)};

    // free run after reset: two ticks in 25 cycles, nothing acknowledged
    do_reset();
    check("reset_time", 64'(rtc_wdata), 64'(RST_T));
    done_cnt = 0;
    run(25);
    check("run25_sec", 64'(rtc_wdata[6:0]), 64'h02);
    check("run25_valid", 64'(rtc_wdata_valid), 64'h0);
    check("run25_done_cnt", 64'(done_cnt), 64'h0);

    // write then exactly one tick
    foreach (vecs[i]) begin
      do_reset();
      write(vecs[i].wr);
      check($sformatf("vec%0d_done", i), 64'(rtc_done), 64'h0);
      cycle();
      check($sformatf("vec%0d_ack", i), 64'(rtc_done), 64'h1);
      check($sformatf("vec%0d_valid", i), 64'(rtc_wdata_valid), 64'h1);
      run(8);
      check($sformatf("vec%0d_pre", i), 64'(rtc_wdata), 64'(vecs[i].wr));
      cycle();
      check($sformatf("vec%0d_post", i), 64'(rtc_wdata), 64'(vecs[i].exp));
    end

    // write while stopped, stay frozen, then resume
    do_reset();
    rtc_stop = 1'b1;
    run(3);
    write(pack('h00, 'h01, 'h01, 6, 0, 0, 'h09));
    run(50);
    check("stop_sec", 64'(rtc_wdata[6:0]), 64'h09);
    rtc_stop = 1'b0;
    run(9);
    check("resume_pre", 64'(rtc_wdata[6:0]), 64'h09);
    cycle();
    check("resume_post", 64'(rtc_wdata[6:0]), 64'h10);

    // held pending serviced once; re-request after a one-cycle drop
    do_reset();
    done_cnt = 0;
    rtc_rdata = pack('h11, 'h03, 'h14, 2, 'h01, 'h02, 'h03);
    rtc_pending = 1'b1;
    run(30);
    check("hold_done_cnt", 64'(done_cnt), 64'h1);
    rtc_pending = 1'b0;
    cycle();
    rtc_pending = 1'b1;
    run(5);
    check("rereq_done_cnt", 64'(done_cnt), 64'h2);
    rtc_pending = 1'b0;
    cycle();

    // write colliding with tick, then reset before acknowledge
    do_reset();
    start = 0;
    while (m_div != CF - 1 && start < 3 * CF) begin
      cycle();
      start++;
    end
    check("div_wait_timeout", 64'(start < 3 * CF), 64'h1);
    v = pack('h30, 'h08, 'h31, 3, 'h23, 'h59, 'h59);
    write(v);
    check("collide_no_inc", 64'(rtc_wdata), 64'(v));
    reset = 1'b1;
    cycle();
    check("abort_done", 64'(rtc_done), 64'h0);
    check("abort_time", 64'(rtc_wdata), 64'(RST_T));
    check("abort_valid", 64'(rtc_wdata_valid), 64'h0);
    reset = 1'b0;

    // randomized traffic against the model
    pend = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(299, 0) == 0);
      rtc_stop = ($urandom_range(7, 0) == 0);
      if (pend) pend = ($urandom_range(3, 0) != 0);
      else begin
        pend = ($urandom_range(9, 0) == 0);
        if (pend) begin
          if ($urandom_range(7, 0) == 0)
            rtc_rdata = {$urandom(), $urandom()};
          else
            rtc_rdata = pack(rand_bcd(0, 99), rand_bcd(1, 12), rand_bcd(26, 31),
                             int'($urandom_range(6, 0)), rand_bcd(22, 23),
                             rand_bcd(58, 59), rand_bcd(50, 59));
        end
      end
      rtc_pending = pend;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
